// File: rtl/control_types_pkg.sv
// Shared control encodings for the pipeline: forwarding source select and
// helpers used by the forwarding unit and the EX-stage operand muxes.
package control_types_pkg;

   localparam int REG_IDX_W = 5;

   // 2'b11 is reserved and never driven by the forwarding logic.
   typedef enum logic [1:0] {
      FWD_SRC_ID  = 2'b00,
      FWD_SRC_MEM = 2'b01,
      FWD_SRC_WB  = 2'b10
   } forwarding_src_t;

   // Number of operands (0..2) whose select equals src.
   function automatic logic [1:0] count_src(
      input forwarding_src_t sel_a,
      input forwarding_src_t sel_b,
      input forwarding_src_t src
   );
      return {1'b0, (sel_a == src)} + {1'b0, (sel_b == src)};
   endfunction

endpackage

// File: rtl/forwarding_select.sv
// Per-operand forwarding decision: MEM (younger write) beats WB, x0 never
// forwards, and a matching index with its write enable low is ignored.
module forwarding_select
   import control_types_pkg::*;
(
   input  logic [REG_IDX_W-1:0] reg_idx,
   input  logic [REG_IDX_W-1:0] mem_wr_idx,
   input  logic                 mem_wr_en,
   input  logic [REG_IDX_W-1:0] wb_wr_idx,
   input  logic                 wb_wr_en,
   output forwarding_src_t      sel
);

   logic reg_live;
   logic mem_hit;
   logic wb_hit;

   assign reg_live = (reg_idx != '0);
   assign mem_hit  = reg_live && mem_wr_en && (mem_wr_idx == reg_idx);
   assign wb_hit   = reg_live && wb_wr_en  && (wb_wr_idx  == reg_idx);

   always_comb begin
      if (mem_hit) begin
         sel = FWD_SRC_MEM;
      end else if (wb_hit) begin
         sel = FWD_SRC_WB;
      end else begin
         sel = FWD_SRC_ID;
      end
   end

endmodule

// File: rtl/forwarding_unit.sv
// Operand-forwarding selector beside the EX stage. Defining FWD_PERF_CNT_EN
// adds saturating forwarding-event counters (fwd_mem_cnt, fwd_wb_cnt).
module forwarding_unit
   import control_types_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] ex_reg1_idx,
   input  logic [REG_IDX_W-1:0] ex_reg2_idx,
   input  logic [REG_IDX_W-1:0] mem_reg_wr_idx,
   input  logic                 mem_reg_wr_en,
   input  logic [REG_IDX_W-1:0] wb_reg_wr_idx,
   input  logic                 wb_reg_wr_en,
   output forwarding_src_t      alu_reg1_forwarding_ctrl,
   output forwarding_src_t      alu_reg2_forwarding_ctrl
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] fwd_mem_cnt,
   output logic [CNT_WIDTH-1:0] fwd_wb_cnt
`endif
);

   forwarding_select u_sel_reg1 (
      .reg_idx    (ex_reg1_idx),
      .mem_wr_idx (mem_reg_wr_idx),
      .mem_wr_en  (mem_reg_wr_en),
      .wb_wr_idx  (wb_reg_wr_idx),
      .wb_wr_en   (wb_reg_wr_en),
      .sel        (alu_reg1_forwarding_ctrl)
   );

   forwarding_select u_sel_reg2 (
      .reg_idx    (ex_reg2_idx),
      .mem_wr_idx (mem_reg_wr_idx),
      .mem_wr_en  (mem_reg_wr_en),
      .wb_wr_idx  (wb_reg_wr_idx),
      .wb_wr_en   (wb_reg_wr_en),
      .sel        (alu_reg2_forwarding_ctrl)
   );

`ifdef FWD_PERF_CNT_EN
   logic [1:0] mem_inc;
   logic [1:0] wb_inc;

   assign mem_inc = count_src(alu_reg1_forwarding_ctrl, alu_reg2_forwarding_ctrl, FWD_SRC_MEM);
   assign wb_inc  = count_src(alu_reg1_forwarding_ctrl, alu_reg2_forwarding_ctrl, FWD_SRC_WB);

   // One guard bit catches the carry; the counter then pins at all-ones.
   function automatic logic [CNT_WIDTH-1:0] sat_add(
      input logic [CNT_WIDTH-1:0] cnt,
      input logic [1:0]           inc
   );
      logic [CNT_WIDTH:0] sum;
      sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
      return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_mem_cnt <= '0;
         fwd_wb_cnt  <= '0;
      end else begin
         fwd_mem_cnt <= sat_add(fwd_mem_cnt, mem_inc);
         fwd_wb_cnt  <= sat_add(fwd_wb_cnt, wb_inc);
      end
   end
`else
   // Without counters the block is purely combinational; clk and rst stay as ports.
   wire unused_ok = &{1'b0, clk, rst, CNT_WIDTH[0]};
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed plan vectors plus random vectors against
// a pending-write list model; counter checks when FWD_PERF_CNT_EN is defined.
module tb_forwarding_unit;
   import control_types_pkg::*;

   localparam int TB_CNT_W = 4;
   localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [4:0]          rs1 = '0;
   logic [4:0]          rs2 = '0;
   logic [4:0]          mem_idx = '0;
   logic                mem_en = 1'b0;
   logic [4:0]          wb_idx = '0;
   logic                wb_en = 1'b0;
   forwarding_src_t     sel1;
   forwarding_src_t     sel2;
`ifdef FWD_PERF_CNT_EN
   logic [TB_CNT_W-1:0] fwd_mem_cnt;
   logic [TB_CNT_W-1:0] fwd_wb_cnt;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int m_mem = 0;
   int m_wb  = 0;
   logic [1:0] exp_q[$];

   forwarding_unit #(.CNT_WIDTH(TB_CNT_W)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .ex_reg1_idx              (rs1),
      .ex_reg2_idx              (rs2),
      .mem_reg_wr_idx           (mem_idx),
      .mem_reg_wr_en            (mem_en),
      .wb_reg_wr_idx            (wb_idx),
      .wb_reg_wr_en             (wb_en),
      .alu_reg1_forwarding_ctrl (sel1),
      .alu_reg2_forwarding_ctrl (sel2)
`ifdef FWD_PERF_CNT_EN
      ,
      .fwd_mem_cnt              (fwd_mem_cnt),
      .fwd_wb_cnt               (fwd_wb_cnt)
`endif
   );

   // Clock / reset block: reset is driven from the stimulus process.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: pending writes listed youngest first; first live match wins.
   function automatic forwarding_src_t ref_src(input logic [4:0] rs);
      logic [4:0]      w_idx[2];
      logic            w_en[2];
      forwarding_src_t w_src[2];
      w_idx[0] = mem_idx; w_en[0] = mem_en; w_src[0] = FWD_SRC_MEM;
      w_idx[1] = wb_idx;  w_en[1] = wb_en;  w_src[1] = FWD_SRC_WB;
      if (rs == 5'd0) return FWD_SRC_ID;
      for (int i = 0; i < 2; i++) begin
         if (w_en[i] && w_idx[i] == rs) return w_src[i];
      end
      return FWD_SRC_ID;
   endfunction

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] mi, input logic me,
                        input logic [4:0] wi, input logic we);
      logic [1:0] e1, e2;
      rs1 = r1; rs2 = r2; mem_idx = mi; mem_en = me; wb_idx = wi; wb_en = we;
      exp_q.push_back(ref_src(r1));
      exp_q.push_back(ref_src(r2));
      #1;
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      check_eq("sel1", 32'(sel1), 32'(e1));
      check_eq("sel2", 32'(sel2), 32'(e2));
   endtask

   task automatic step();
      int inc_m, inc_w;
      inc_m = int'(ref_src(rs1) == FWD_SRC_MEM) + int'(ref_src(rs2) == FWD_SRC_MEM);
      inc_w = int'(ref_src(rs1) == FWD_SRC_WB)  + int'(ref_src(rs2) == FWD_SRC_WB);
      @(posedge clk);
      if (rst) begin
         m_mem = 0;
         m_wb  = 0;
      end else begin
         m_mem = (m_mem + inc_m > CNT_MAX) ? CNT_MAX : m_mem + inc_m;
         m_wb  = (m_wb + inc_w > CNT_MAX) ? CNT_MAX : m_wb + inc_w;
      end
      #1;
`ifdef FWD_PERF_CNT_EN
      check_eq("fwd_mem_cnt", 32'(fwd_mem_cnt), 32'(m_mem));
      check_eq("fwd_wb_cnt", 32'(fwd_wb_cnt), 32'(m_wb));
`endif
   endtask

   initial begin
      // Reset held for two edges; selects must still follow inputs meanwhile.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      drive(5'd8, 5'd8, 5'd8, 1'b1, 5'd3, 1'b1);
      step();
      rst = 1'b0;

      // Directed plan vectors.
      drive(5'd1,  5'd2, 5'd3,  1'b1, 5'd4,  1'b1); step();
      drive(5'd5,  5'd2, 5'd5,  1'b1, 5'd4,  1'b1); step();
      drive(5'd1,  5'd7, 5'd3,  1'b1, 5'd7,  1'b1); step();
      drive(5'd10, 5'd2, 5'd10, 1'b1, 5'd10, 1'b1); step();
      drive(5'd0,  5'd0, 5'd0,  1'b1, 5'd0,  1'b1); step();
      drive(5'd1,  5'd9, 5'd9,  1'b0, 5'd9,  1'b0); step();
      drive(5'd9,  5'd9, 5'd9,  1'b0, 5'd9,  1'b1); step();

      // Counter sequence: reset, three double-MEM edges, reset again.
      rst = 1'b1; step(); step();
      rst = 1'b0;
      drive(5'd6, 5'd6, 5'd6, 1'b1, 5'd1, 1'b0);
      step(); step(); step();
`ifdef FWD_PERF_CNT_EN
      check_eq("mem_cnt_after_3", 32'(fwd_mem_cnt), 32'd6);
`endif
      rst = 1'b1; step();
      rst = 1'b0;

      // Saturation: run both counters past all-ones.
      drive(5'd6, 5'd6, 5'd6, 1'b1, 5'd1, 1'b0);
      for (int i = 0; i < 10; i++) step();
      drive(5'd12, 5'd12, 5'd3, 1'b1, 5'd12, 1'b1);
      for (int i = 0; i < 10; i++) step();
`ifdef FWD_PERF_CNT_EN
      check_eq("mem_cnt_sat", 32'(fwd_mem_cnt), 32'(CNT_MAX));
      check_eq("wb_cnt_sat", 32'(fwd_wb_cnt), 32'(CNT_MAX));
`endif
      rst = 1'b1; step();
      rst = 1'b0;

      // Random vectors on a narrow index range so matches are frequent.
      for (int i = 0; i < 300; i++) begin
         drive(5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
               5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 19) == 0) rst = 1'b1;
         step();
         rst = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
